// File: rtl/psum_ofifo.sv
// Per-column output FIFOs behind the systolic array; pops one full row at a time.
// Optional PSUM_OFIFO_RELU_EN clamps negative popped values to zero.
module psum_ofifo #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [psum_bw*col-1:0]   in,
   input  logic [col-1:0]           wr,
   input  logic                     rd,
   output logic                     o_valid,
   output logic                     o_full,
   output logic                     o_ready,
   output logic [psum_bw*col-1:0]   out,
   output logic                     out_valid,
   output logic                     ovf
);

   localparam int aw = $clog2(depth);
   localparam int cw = aw + 1;
   localparam logic [cw-1:0] depth_cnt = cw'(depth);

   logic [col-1:0] nonempty;
   logic [col-1:0] full;
   logic [col-1:0] accept;
   logic [col-1:0] dropped;
   logic           pop;
   logic           out_valid_reg;
   logic           ovf_reg;

   // Status flags come only from registered counts, never from this cycle's rd/wr.
   assign o_valid   = &nonempty;
   assign o_full    = |full;
   assign o_ready   = ~o_full;
   assign pop       = rd & o_valid;
   assign out_valid = out_valid_reg;
   assign ovf       = ovf_reg;

   generate
      for (genvar gi = 0; gi < col; gi++) begin : g_col
         logic [psum_bw-1:0] mem [depth];
         logic [aw-1:0]      wptr_reg;
         logic [aw-1:0]      rptr_reg;
         logic [cw-1:0]      count_reg;
         logic [cw-1:0]      count_next;
         logic [psum_bw-1:0] wdata;
         logic [psum_bw-1:0] rdata;
         logic [psum_bw-1:0] pdata;
         logic [psum_bw-1:0] out_col_reg;

         assign wdata        = in[psum_bw*gi +: psum_bw];
         assign nonempty[gi] = (count_reg != '0);
         assign full[gi]     = (count_reg == depth_cnt);
         // A full column still accepts when the row pop frees a slot in the same cycle.
         assign accept[gi]   = wr[gi] & (~full[gi] | pop);
         assign dropped[gi]  = wr[gi] & full[gi] & ~pop;

         always_comb begin
            count_next = count_reg;
            if (accept[gi] && !pop)
               count_next = count_reg + cw'(1);
            else if (!accept[gi] && pop)
               count_next = count_reg - cw'(1);
         end

         always_ff @(posedge clk) begin
            if (accept[gi])
               mem[wptr_reg] <= wdata;
         end

         // Pop reads an entry written on an earlier cycle; a same-edge write to the
         // same slot (full + pop) lands after the old value is captured.
         assign rdata = mem[rptr_reg];

`ifdef PSUM_OFIFO_RELU_EN
         assign pdata = rdata[psum_bw-1] ? '0 : rdata;
`else
         assign pdata = rdata;
`endif

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               wptr_reg    <= '0;
               rptr_reg    <= '0;
               count_reg   <= '0;
               out_col_reg <= '0;
            end else begin
               if (accept[gi])
                  wptr_reg <= wptr_reg + aw'(1);
               if (pop) begin
                  rptr_reg    <= rptr_reg + aw'(1);
                  out_col_reg <= pdata;
               end
               count_reg <= count_next;
            end
         end

         assign out[psum_bw*gi +: psum_bw] = out_col_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_reg <= 1'b0;
         ovf_reg       <= 1'b0;
      end else begin
         out_valid_reg <= pop;
         ovf_reg       <= ovf_reg | (|dropped);
      end
   end

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for psum_ofifo: skewed fill, overflow, pop+write at full,
// wrap-around streaming, empty read, async reset and the optional ReLU clamp.
module tb_psum_ofifo;

   localparam int COL   = 8;
   localparam int BW    = 16;
   localparam int DEPTH = 64;
   localparam int W     = COL * BW;

   logic          clk;
   logic          reset;
   logic [W-1:0]  in_bus;
   logic [COL-1:0] wr;
   logic          rd;
   logic          o_valid;
   logic          o_full;
   logic          o_ready;
   logic [W-1:0]  out_bus;
   logic          out_valid;
   logic          ovf;

   int checks;
   int errors;

   psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in_bus),
      .wr        (wr),
      .rd        (rd),
      .o_valid   (o_valid),
      .o_full    (o_full),
      .o_ready   (o_ready),
      .out       (out_bus),
      .out_valid (out_valid),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, got, want);
      end else begin
         $display("[%0t] ok %s = %h", $time, tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] row_val(input int i);
      logic [W-1:0] r;
      for (int c = 0; c < COL; c++) r[c*BW +: BW] = {8'(i), 8'(c)};
      return r;
   endfunction

   function automatic logic [W-1:0] stream_val(input int t);
      logic [W-1:0] r;
      for (int c = 0; c < COL; c++) r[c*BW +: BW] = 16'(16'h2000 + t*8 + c);
      return r;
   endfunction

   initial begin
      logic [W-1:0] exp_row;
      logic [W-1:0] beef_row;
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      in_bus = '0;
      wr     = '0;
      rd     = 1'b0;
      tick();
      tick();
      check("rst_o_valid", W'(o_valid), W'(0));
      check("rst_o_full", W'(o_full), W'(0));
      check("rst_o_ready", W'(o_ready), W'(1));
      check("rst_out", out_bus, '0);
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_ovf", W'(ovf), W'(0));
      reset = 1'b1;
      tick();

      // Skewed fill: one column per cycle
      exp_row = '0;
      for (int c = 0; c < COL; c++) begin
         in_bus = '0;
         in_bus[c*BW +: BW] = 16'(16'h0100 + c);
         exp_row[c*BW +: BW] = 16'(16'h0100 + c);
         wr = COL'(1) << c;
         tick();
         check($sformatf("skew_o_valid_c%0d", c), W'(o_valid), W'(c == COL-1));
      end
      wr = '0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("skew_out_valid", W'(out_valid), W'(1));
      check("skew_out", out_bus, exp_row);
      tick();
      check("skew_out_valid_drop", W'(out_valid), W'(0));
      check("skew_out_hold", out_bus, exp_row);
      check("skew_empty", W'(o_valid), W'(0));

      // Full and overflow on column 0 only
      for (int i = 0; i < DEPTH + 1; i++) begin
         in_bus = '0;
         in_bus[BW-1:0] = 16'(i);
         wr = COL'(1);
         tick();
         if (i == DEPTH-2) check("ovf_not_full_63", W'(o_full), W'(0));
         if (i == DEPTH-1) begin
            check("ovf_full_64", W'(o_full), W'(1));
            check("ovf_ready_64", W'(o_ready), W'(0));
            check("ovf_clear_64", W'(ovf), W'(0));
            check("ovf_valid_64", W'(o_valid), W'(0));
         end
      end
      wr = '0;
      check("ovf_set_65", W'(ovf), W'(1));
      for (int i = 0; i < 10; i++) tick();
      check("ovf_sticky", W'(ovf), W'(1));
      #2 reset = 1'b0;
      #1;
      check("ovf_reset_clear", W'(ovf), W'(0));
      check("ovf_reset_full", W'(o_full), W'(0));
      reset = 1'b1;
      tick();

      // Fill all columns, then pop and write at full in the same cycle
      for (int i = 0; i < DEPTH; i++) begin
         in_bus = row_val(i);
         wr = '1;
         tick();
      end
      check("full_all", W'(o_full), W'(1));
      for (int c = 0; c < COL; c++) beef_row[c*BW +: BW] = 16'hBEEF;
      in_bus = beef_row;
      wr = '1;
      rd = 1'b1;
      tick();
      wr = '0;
      check("pw_out_valid", W'(out_valid), W'(1));
      check("pw_out_row0", out_bus, row_val(0));
      check("pw_still_full", W'(o_full), W'(1));
      check("pw_ovf", W'(ovf), W'(0));
      for (int j = 1; j <= DEPTH; j++) begin
         rd = 1'b1;
         tick();
         if (j == DEPTH) check("pw_last_beef", out_bus, beef_row);
         else if (j % 16 == 0) check($sformatf("pw_row%0d", j), out_bus, row_val(j));
      end
      rd = 1'b0;
      check("pw_drained", W'(o_valid), W'(0));

      // Wrap-around streaming, one write and one pop per cycle
      for (int t = 0; t <= 200; t++) begin
         if (t < 200) begin
            in_bus = stream_val(t);
            wr = '1;
         end else begin
            wr = '0;
         end
         rd = 1'b1;
         tick();
         if (t >= 1) begin
            check($sformatf("wrap_v%0d", t-1), W'(out_valid), W'(1));
            check($sformatf("wrap_d%0d", t-1), out_bus, stream_val(t-1));
         end
      end
      rd = 1'b0;
      wr = '0;
      tick();

      // Read while empty is ignored
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("empty_rd_no_valid", W'(out_valid), W'(0));
      check("empty_rd_out_hold", out_bus, stream_val(199));

      // Fill 5 rows, pop one, then async reset mid-cycle
      for (int i = 0; i < 5; i++) begin
         in_bus = row_val(i + 10);
         wr = '1;
         tick();
      end
      wr = '0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("pre_rst_out_valid", W'(out_valid), W'(1));
      check("pre_rst_o_valid", W'(o_valid), W'(1));
      #2 reset = 1'b0;
      #1;
      check("mid_rst_o_valid", W'(o_valid), W'(0));
      check("mid_rst_out_valid", W'(out_valid), W'(0));
      check("mid_rst_ovf", W'(ovf), W'(0));
      check("mid_rst_o_ready", W'(o_ready), W'(1));
      check("mid_rst_out", out_bus, '0);
      #1 reset = 1'b1;
      tick();
      check("post_rst_empty", W'(o_valid), W'(0));

      // Signed row through the optional clamp
      in_bus = '0;
      in_bus[BW-1:0]    = 16'd7;
      in_bus[BW +: BW]  = 16'hFFFD;
      wr = '1;
      tick();
      wr = '0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      exp_row = '0;
      exp_row[BW-1:0] = 16'd7;
`ifdef PSUM_OFIFO_RELU_EN
      exp_row[BW +: BW] = 16'h0000;
`else
      exp_row[BW +: BW] = 16'hFFFD;
`endif
      check("relu_row", out_bus, exp_row);
      check("relu_valid", W'(out_valid), W'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output collection stage directly downstream of the systolic MAC array. It captures the per-column partial sums that leave the array's south edge, each column qualified by its own valid bit. Because the array is skewed, columns arrive on different cycles, so each column gets its own FIFO. Complete rows, one entry from every column, are handed to the SRAM write-back path through a single read handshake.

## Interface
Parameters:
- col, 8: number of array columns, one FIFO per column.
- psum_bw, 16: width of each column's partial sum, signed two's complement.
- depth, 64: entries per column FIFO; must be a power of 2, at least 2.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- reset  input  1: asynchronous, active-low; asserting it (0) clears all state immediately.
- in  input  psum_bw*col: array out_s bus; column c is in[psum_bw*(c+1)-1 : psum_bw*c].
- wr  input  col: per-column write strobe, driven by the array's valid bus.
- rd  input  1: consumer request to pop one full row.
- o_valid  output  1: every column FIFO holds at least one entry.
- o_full  output  1: at least one column FIFO holds depth entries.
- o_ready  output  1: equals ~o_full.
- out  output  psum_bw*col: registered popped row, column c in the same bit slice as in.
- out_valid  output  1: one-cycle pulse; out holds newly popped data.
- ovf  output  1: sticky flag; a write was dropped.

## Operation
- Per-column state: storage of depth x psum_bw, write pointer, read pointer, and count of width log2(depth)+1. Pointers wrap modulo depth.
- Pop condition: pop = rd & o_valid. A pop advances every column's read pointer together and decrements every count.
- rd while o_valid=0 is ignored: no pointer movement, no out_valid.
- Write to column c is accepted when wr[c] & (count_c < depth | pop).
  - In that case in[c] is stored at wptr_c and wptr_c advances.
  - A full column writing in the same cycle as a pop is accepted.
- Write to a full column with no pop is dropped; ovf is set to 1 and held until reset.
- Count update per column: +1 on write-only, -1 on pop-only, unchanged when both or neither occur.
- No write-to-read bypass. An entry written in cycle N can only count toward o_valid from cycle N+1.
- Columns are fully independent on the write side. Any subset of wr bits may be high in any cycle.
- o_valid, o_full and o_ready are combinational from the counts. They do not depend on rd or wr in the current cycle.
- Data is passed through unchanged: no sign manipulation or saturation, except as described under Configuration.

## Timing
- Reset (reset=0) forces: all pointers and counts to 0, out=0, out_valid=0, ovf=0, o_valid=0, o_full=0, o_ready=1. Storage contents need not be cleared.
- Reset asserted mid-operation discards all queued entries. The first cycle after release behaves as empty.
- Write latency: a write sampled at edge N makes its column non-empty after edge N.
- Read latency: a pop sampled at edge N presents the row on out, with out_valid=1, after edge N, i.e. one cycle.
- out holds its last value while out_valid=0.
- Back-to-back pops are allowed every cycle while o_valid stays 1. Throughput is one row per cycle.
- Wrap-around: the entry following index depth-1 is index 0, with no bubble.

## Configuration
- PSUM_OFIFO_RELU_EN
  - Defined: each column of a popped row is registered as 0 if its sign bit is 1, otherwise unchanged. Storage and ovf are unaffected.
  - Undefined: popped data is registered unchanged.

## Test plan
- Skewed fill: col=8, depth=64. Assert wr[c] with in[c]=16'h0100+c in cycle c, for c=0..7, one column per cycle.
  - o_valid stays 0 until the edge after wr[7].
  - A subsequent rd gives out = {16'h0107, …, 16'h0100} with out_valid=1 one cycle later.
- Full and overflow: write column 0 sixty-five times and no other column.
  - o_full=1 after the 64th write.
  - The 65th write is dropped and ovf=1. ovf stays 1 through 10 idle cycles.
- Simultaneous pop and write at full: fill all columns to 64, then assert rd and wr=8'hFF with value 16'hBEEF in the same cycle.
  - The write is accepted, counts remain 64, ovf=0.
  - After 64 more pops, the last row equals 16'hBEEF in every column.
- Wrap-around: stream 200 rows at one write and one pop per cycle.
  - out sequence matches the input order exactly, with no gaps after the first row.
- rd while empty, then reset mid-operation: pulse rd with o_valid=0.
  - No out_valid and out unchanged.
  - Then fill 5 rows and drive reset=0 asynchronously mid-cycle. o_valid, out_valid and ovf drop to 0 immediately and o_ready=1.
- Configuration check with PSUM_OFIFO_RELU_EN defined: pop row values {-3, 7} on columns 1 and 0.
  - out columns read {0, 7}.
  - Without the macro the same row reads {16'hFFFD, 7}.
